hilo_muldiv_unit: RTL and testbench

EX-stage multiply/divide unit owning the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It produces the HI/LO values that mfhi/mflo read in ID/EX; their results then travel down the pipeline and are forwarded by the forwarding units. Multiply takes a fixed short latency; divide is a 32-step iterative restoring divider. While an operation is in flight, the unit holds the EX stage via `stall_req`.

---
 rtl/hilo_muldiv_unit_if.sv | 22 ++
 rtl/hilo_muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// EX-stage mul/div request bundle between the pipeline and the HI/LO unit.
// master: EX control drives start/op/operands; slave: unit answers stall_req/done.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             stall_req;
  logic             done;

  modport master (
    output start, op, src_a, src_b,
    input  stall_req, done
  );

  modport slave (
    input  start, op, src_a, src_b,
    output stall_req, done
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: one-cycle MULT/MULTU, 32-step restoring DIV/DIVU, MTHI/MTLO.
// Ports: clk, resetn, ex (start/op/src_a/src_b -> stall_req/done), flush, hi_we/lo_we/wdata, hi/lo.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  hilo_muldiv_unit_if.slave ex,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic             qneg_q;
  logic             rneg_q;

  logic             accept;
  logic             is_signed;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             last;

  logic [2*WIDTH-1:0] prod_abs;
  logic [2*WIDTH-1:0] prod;

  logic             res_we;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign accept    = (state_q == IDLE) && ex.start && !flush;
  assign is_signed = ~ex.op[0];
  assign sa        = is_signed & ex.src_a[WIDTH-1];
  assign sb        = is_signed & ex.src_b[WIDTH-1];
  assign abs_a     = sa ? -ex.src_a : ex.src_a;
  assign abs_b     = sb ? -ex.src_b : ex.src_b;

  // a_q doubles as the dividend shifter; quotient bits fill it from the LSB.
  assign rem_sh  = {rem_q, a_q[WIDTH-1]};
  assign ge      = rem_sh >= {1'b0, b_q};
  assign rem_nx  = ge ? rem_sh[WIDTH-1:0] - b_q : rem_sh[WIDTH-1:0];
  assign quo_nx  = {a_q[WIDTH-2:0], ge};
  assign last    = (cnt_q == CW'(WIDTH - 1));
  assign quo_fix = qneg_q ? -quo_nx : quo_nx;
  assign rem_fix = rneg_q ? -rem_nx : rem_nx;

  assign prod_abs = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign prod     = qneg_q ? -prod_abs : prod_abs;

  always_comb begin
    state_d = state_q;
    res_we  = 1'b0;
    res_hi  = '0;
    res_lo  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ex.op[1] ? DIV : MUL;
      end
      MUL: begin
        res_we  = 1'b1;
        res_hi  = prod[2*WIDTH-1:WIDTH];
        res_lo  = prod[WIDTH-1:0];
        state_d = DONE;
      end
      DIV: begin
        if (last) begin
          res_we  = 1'b1;
          res_hi  = rem_fix;
          res_lo  = quo_fix;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      res_we  = 1'b0;
    end
  end

  assign ex.stall_req = accept ||
    (((state_q == MUL) || (state_q == DIV)) && !flush);
  assign ex.done = (state_q == DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (accept) begin
      cnt_q  <= '0;
      a_q    <= abs_a;
      b_q    <= abs_b;
      rem_q  <= '0;
      qneg_q <= sa ^ sb;
      rneg_q <= sa;
    end else if (state_q == DIV && !flush) begin
      cnt_q <= cnt_q + 1'b1;
      a_q   <= quo_nx;
      rem_q <= rem_nx;
    end
  end

  // Mul/div result beats a same-edge MTHI/MTLO: the WB write is older.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (res_we) begin
      hi <= res_hi;
      lo <= res_lo;
    end else begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit.
// Scoreboard of expected {hi,lo} popped on each done pulse.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;

  hilo_muldiv_unit_if #(.WIDTH(32)) ex ();

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .ex     (ex),
    .flush  (flush),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .hi     (hi),
    .lo     (lo)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [63:0] sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn && ex.done) begin
      logic [63:0] e;
      done_cnt++;
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_done hi=%h lo=%h", hi, lo);
      end else begin
        e = sb_q.pop_front();
        if ({hi, lo} !== e) begin
          fails++;
          $display("FAIL sb_result got=%h_%h exp=%h", hi, lo, e);
        end
      end
    end
  end

  function automatic logic [63:0] model(logic [1:0] op, logic [31:0] a,
                                        logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    logic [31:0] q;
    logic [31:0] r;
    sa  = a;
    sbv = b;
    case (op)
      2'd0: begin
        sp = 64'(sa) * 64'(sbv);
        return sp;
      end
      2'd1: return {32'b0, a} * {32'b0, b};
      2'd2: begin
        q = sa / sbv;
        r = sa % sbv;
        return {r, q};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp,
                       input int exp_stalls, input string nm);
    int stalls;
    int cyc;
    bit got;
    stalls = 0;
    cyc = 0;
    got = 0;
    sb_q.push_back(exp);
    @(negedge clk);
    flush = 1'b0;
    ex.start = 1'b1;
    ex.op = op;
    ex.src_a = a;
    ex.src_b = b;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (ex.done) begin
        got = 1;
        break;
      end
      if (ex.stall_req) stalls++;
      cyc++;
      @(negedge clk);
    end
    tests++;
    if (!got || stalls != exp_stalls || cyc != exp_stalls) begin
      fails++;
      $display("FAIL %s_latency got_done=%0d stalls=%0d cycles=%0d exp=%0d",
               nm, got, stalls, cyc, exp_stalls);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ex.start = 1'b0;
      flush = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    ex.start = 1'b0;
    ex.op = 2'd0;
    ex.src_a = '0;
    ex.src_b = '0;
    flush = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    tests++;
    if (hi !== 32'h0 || lo !== 32'h0 || ex.stall_req !== 1'b0 ||
        ex.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state hi=%h lo=%h stall=%b done=%b",
               hi, lo, ex.stall_req, ex.done);
    end
  endtask

  task automatic test_mul;
    do_op(2'd0, 32'hFFFFFFFE, 32'h3, 64'hFFFFFFFF_FFFFFFFA, 2, "mult");
    idle(1);
    do_op(2'd1, 32'hFFFFFFFE, 32'h3, 64'h00000002_FFFFFFFA, 2, "multu");
    idle(1);
    do_op(2'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 2,
          "mult_min");
    idle(1);
  endtask

  task automatic test_div;
    do_op(2'd2, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 33, "div");
    idle(1);
    do_op(2'd3, 32'h7, 32'h0, 64'h00000007_FFFFFFFF, 33, "divu_zero");
    idle(1);
    do_op(2'd2, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 33,
          "div_neg_divisor");
    idle(1);
    do_op(2'd3, 32'hFFFFFFFF, 32'h3, 64'h00000000_55555555, 33, "divu_big");
    idle(1);
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom();
      b = $urandom();
      if (b == 0) b = 32'd13;
      if (op == 2'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd5;
      do_op(op, a, b, model(op, a, b), op[1] ? 33 : 2, "random");
      idle(1);
    end
  endtask

  task automatic test_mthi_mtlo;
    // MULTU 0x80000000*2 -> HI=1, LO=0; MTHI collides on the MUL edge.
    sb_q.push_back(64'h00000001_00000000);
    @(negedge clk);
    ex.start = 1'b1;
    ex.op = 2'd1;
    ex.src_a = 32'h80000000;
    ex.src_b = 32'h2;
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0;
    #1;
    tests++;
    if (hi !== 32'h1 || ex.done !== 1'b1) begin
      fails++;
      $display("FAIL mthi_collision hi=%h done=%b exp hi=00000001 done=1",
               hi, ex.done);
    end
    idle(1);
    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'h0000ABCD;
    @(negedge clk);
    lo_we = 1'b0;
    #1;
    tests++;
    if (lo !== 32'h0000ABCD || hi !== 32'h1) begin
      fails++;
      $display("FAIL mtlo_idle lo=%h hi=%h exp lo=0000abcd hi=00000001",
               lo, hi);
    end
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'hCAFEF00D;
    @(negedge clk);
    hi_we = 1'b0;
    #1;
    tests++;
    if (hi !== 32'hCAFEF00D || lo !== 32'h0000ABCD) begin
      fails++;
      $display("FAIL mthi_idle hi=%h lo=%h exp hi=cafef00d", hi, lo);
    end
  endtask

  task automatic test_flush;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    ex.start = 1'b1;
    ex.op = 2'd3;
    ex.src_a = 32'd1000;
    ex.src_b = 32'd7;
    repeat (21) @(negedge clk);
    flush = 1'b1;
    #1;
    tests++;
    if (ex.stall_req !== 1'b0) begin
      fails++;
      $display("FAIL flush_stall got=%b exp=0", ex.stall_req);
    end
    @(negedge clk);
    flush = 1'b0;
    ex.start = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    tests++;
    if (done_cnt != d0 || hi !== 32'hCAFEF00D || lo !== 32'h0000ABCD) begin
      fails++;
      $display("FAIL flush_discard dones=%0d exp=%0d hi=%h lo=%h",
               done_cnt - d0, 0, hi, lo);
    end
    do_op(2'd1, 32'd6, 32'd7, 64'd42, 2, "after_flush");
    idle(1);
  endtask

  task automatic test_reset_mid_div;
    @(negedge clk);
    ex.start = 1'b1;
    ex.op = 2'd3;
    ex.src_a = 32'd12345;
    ex.src_b = 32'd3;
    repeat (11) @(negedge clk);
    #2;
    resetn = 1'b0;
    ex.start = 1'b0;
    #1;
    tests++;
    if (hi !== 32'h0 || lo !== 32'h0 || ex.stall_req !== 1'b0 ||
        ex.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_div hi=%h lo=%h stall=%b done=%b",
               hi, lo, ex.stall_req, ex.done);
    end
    @(negedge clk);
    resetn = 1'b1;
    do_op(2'd3, 32'd12345, 32'd3, {32'd0, 32'd4115}, 33, "after_reset");
    idle(1);
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = done_cnt;
    do_op(2'd0, 32'd5, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFF1, 2, "b2b_first");
    do_op(2'd0, 32'h10000, 32'h10000, 64'h00000001_00000000, 2, "b2b_second");
    idle(1);
    tests++;
    if (done_cnt - d0 != 2) begin
      fails++;
      $display("FAIL b2b_done_pulses got=%0d exp=2", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_mthi_mtlo;
    test_flush;
    test_reset_mid_div;
    test_back_to_back;
    test_random;
    idle(3);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover pending=%0d exp=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
